// File: rtl/cave_mem_pkg.sv
// cave_mem_pkg: shared types and defaults for the cave memory read-port path.
package cave_mem_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              wait_n;
    logic              valid;
  } rd_port_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin find-first starting one past the last winner.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(last_i) + k) % N]) begin
        idx_o = IW'((int'(last_i) + k) % N);
        any_o = 1'b1;
      end
  end
endmodule

// File: rtl/read_port_arbiter.sv
// read_port_arbiter: round-robin share of one handshake read port, one read in flight,
// with a watchdog that abandons reads whose data never arrives.
module read_port_arbiter
  import cave_mem_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int TIMEOUT    = 255
) (
  input  logic                          io_targetClock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            io_in_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] io_in_addr,
  output logic [NUM_REQ-1:0]            io_in_wait_n,
  output logic [NUM_REQ-1:0]            io_in_valid,
  output logic [DATA_WIDTH-1:0]         io_in_dout,
  output logic                          io_out_rd,
  output logic [ADDR_WIDTH-1:0]         io_out_addr,
  input  logic [DATA_WIDTH-1:0]         io_out_dout,
  input  logic                          io_out_wait_n,
  input  logic                          io_out_valid,
  output logic [NUM_REQ-1:0]            io_grant,
  output logic                          io_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e                state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d, last_q, last_d, pick;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  any, done, expire;
  logic [NUM_REQ-1:0]    oh;

  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i (io_in_rd),
    .last_i(last_q),
    .idx_o (pick),
    .any_o (any)
  );

  assign oh     = NUM_REQ'(1) << owner_q;
  assign done   = (state_q == REQ && io_out_wait_n && io_out_valid) || (state_q == WAIT && io_out_valid);
  assign expire = state_q == WAIT && !io_out_valid && cnt_q == CW'(TIMEOUT - 1);

  always_ff @(posedge io_targetClock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    last_d  = (done || expire) ? owner_q : last_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = REQ;
        owner_d = pick;
        addr_d  = io_in_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      REQ: if (io_out_wait_n) begin
        state_d = io_out_valid ? IDLE : WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        state_d = (io_out_valid || expire) ? IDLE : WAIT;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_out_rd    = state_q == REQ;
    io_out_addr  = addr_q;
    io_grant     = state_q == IDLE ? '0 : oh;
    io_in_wait_n = (state_q == REQ && io_out_wait_n) ? oh : '0;
    io_in_valid  = done ? oh : '0;
    io_timeout   = expire;
    io_in_dout   = io_out_dout;
  end
endmodule

// File: tb/tb_read_port_arbiter.sv
// tb_read_port_arbiter: directed table, corner sequences and random traffic vs a reference model.
module tb_read_port_arbiter;
  localparam int TO = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_rd = '0;
  logic [19:0] addr_r [3];
  logic [59:0] in_addr;
  logic [2:0]  in_wn, in_v, grant;
  logic [15:0] in_dout, out_dout = '0;
  logic        out_rd, out_wn = 1'b0, out_v = 1'b0, tmo;
  logic [19:0] out_addr;

  int          n_vec = 0, n_err = 0;
  int          m_owner, m_last, m_waited;
  bit          m_acc;
  logic [19:0] m_addr;
  logic        s_rd, s_to;
  logic [2:0]  s_grant, s_wn, s_v;
  logic [19:0] s_addr;

  typedef struct {
    logic [2:0]  rd;
    logic        wn, v;
    logic [15:0] d;
    logic        e_rd;
    logic [19:0] e_addr;
    logic [2:0]  e_grant, e_wn, e_v;
  } vec_t;
  vec_t tbl [8];

  assign in_addr = {addr_r[2], addr_r[1], addr_r[0]};
  always #5 clk = ~clk;

  read_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(20), .DATA_WIDTH(16), .TIMEOUT(TO)) dut (
    .io_targetClock(clk), .reset(rst), .io_in_rd(in_rd), .io_in_addr(in_addr),
    .io_in_wait_n(in_wn), .io_in_valid(in_v), .io_in_dout(in_dout),
    .io_out_rd(out_rd), .io_out_addr(out_addr), .io_out_dout(out_dout),
    .io_out_wait_n(out_wn), .io_out_valid(out_v), .io_grant(grant), .io_timeout(tmo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_acc = 0; m_waited = 0; m_last = 2; m_addr = '0;
  endtask

  task automatic step(input logic r, input logic [2:0] rd, input logic wn, input logic v, input logic [15:0] d);
    logic [2:0] oh;
    logic       busy, e_to;
    @(negedge clk);
    rst = r; in_rd = rd; out_wn = wn; out_v = v; out_dout = d;
    #1;
    busy = m_owner >= 0;
    oh   = busy ? 3'(1 << m_owner) : 3'b0;
    e_to = busy && m_acc && !v && (m_waited + 1 == TO);
    chk("model", 64'({out_rd, out_addr, grant, in_wn, in_v, tmo, in_dout}),
        64'({busy && !m_acc, m_addr, oh, (busy && !m_acc && wn) ? oh : 3'b0,
             (busy && ((!m_acc && wn && v) || (m_acc && v))) ? oh : 3'b0, e_to, d}));
    s_rd = out_rd; s_addr = out_addr; s_grant = grant; s_wn = in_wn; s_v = in_v; s_to = tmo;
    @(posedge clk);
    if (r) model_reset();
    else if (!busy) begin
      for (int k = 1; k <= 3; k++) begin
        int j;
        j = (m_last + k) % 3;
        if (rd[j] && m_owner < 0) begin m_owner = j; m_addr = addr_r[j]; m_acc = 0; end
      end
    end else if (!m_acc) begin
      if (wn && v) begin m_last = m_owner; m_owner = -1; end
      else if (wn) begin m_acc = 1; m_waited = 0; end
    end else if (v || m_waited + 1 == TO) begin
      m_last = m_owner; m_owner = -1;
    end else m_waited++;
  endtask

  initial begin
    int order [$];
    int cnt, at;
    logic [2:0] pend;
    for (int i = 0; i < 3; i++) addr_r[i] = '0;
    tbl[0] = '{3'b010, 0, 0, 16'h0,    0, 20'h0,     3'b000, 3'b000, 3'b000};
    tbl[1] = '{3'b010, 0, 0, 16'h0,    1, 20'h12345, 3'b010, 3'b000, 3'b000};
    tbl[2] = '{3'b010, 0, 0, 16'h0,    1, 20'h12345, 3'b010, 3'b000, 3'b000};
    tbl[3] = '{3'b010, 1, 0, 16'h0,    1, 20'h12345, 3'b010, 3'b010, 3'b000};
    tbl[4] = '{3'b000, 0, 0, 16'h0,    0, 20'h12345, 3'b010, 3'b000, 3'b000};
    tbl[5] = '{3'b000, 0, 0, 16'h0,    0, 20'h12345, 3'b010, 3'b000, 3'b000};
    tbl[6] = '{3'b000, 0, 1, 16'hBEEF, 0, 20'h12345, 3'b010, 3'b000, 3'b010};
    tbl[7] = '{3'b000, 0, 0, 16'h0,    0, 20'h12345, 3'b000, 3'b000, 3'b000};
    repeat (2) @(posedge clk);
    model_reset();
    addr_r[1] = 20'h12345;
    for (int i = 0; i < 8; i++) begin
      step(0, tbl[i].rd, tbl[i].wn, tbl[i].v, tbl[i].d);
      chk($sformatf("table[%0d]", i), 64'({s_rd, s_addr, s_grant, s_wn, s_v}),
          64'({tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_grant, tbl[i].e_wn, tbl[i].e_v}));
    end

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 3'b111, 1, 1, 16'(i));
      if (s_rd) order.push_back(s_grant == 3'b001 ? 0 : s_grant == 3'b010 ? 1 : s_grant == 3'b100 ? 2 : 9);
    end
    chk("rr_count", 64'(order.size()), 64'd6);
    for (int i = 0; i < order.size() && i < 6; i++) chk($sformatf("rr_order[%0d]", i), 64'(order[i]), 64'(i % 3));

    step(1, 0, 0, 0, 0);
    addr_r[0] = 20'h00ABC;
    cnt = 0;
    step(0, 3'b001, 0, 0, 0);
    step(0, 3'b001, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 3'b000, 0, 0, 0);
    chk("drop_rd_still_issued", 64'({s_rd, s_addr}), 64'({1'b1, 20'h00ABC}));
    step(0, 3'b000, 1, 0, 0);
    cnt += int'(s_v[0]);
    for (int i = 0; i < 3; i++) begin step(0, 3'b000, 0, i == 0, 16'h1234); cnt += int'(s_v[0]); end
    chk("drop_rd_valid_once", 64'(cnt), 64'd1);

    step(1, 0, 0, 0, 0);
    cnt = 0; at = -1;
    step(0, 3'b100, 0, 0, 0);
    step(0, 3'b100, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 3'b000, 0, i == 10, 16'h5A5A);
      if (s_to) begin cnt++; at = i; end
      if (i == 10) chk("late_valid_dropped", 64'(s_v), 64'd0);
    end
    chk("timeout_pulses", 64'(cnt), 64'd1);
    chk("timeout_cycle", 64'(at), 64'd8);

    step(1, 0, 0, 0, 0);
    step(0, 3'b010, 0, 0, 0);
    step(0, 3'b010, 1, 0, 0);
    step(0, 3'b101, 0, 0, 0);
    step(1, 3'b101, 0, 0, 0);
    step(0, 3'b101, 0, 0, 16'h0);
    chk("reset_outputs_zero", 64'({s_rd, s_addr, s_grant, s_wn, s_v, s_to}), 64'd0);
    step(0, 3'b101, 0, 0, 0);
    chk("reset_priority_req0", 64'(s_grant), 64'(3'b001));

    step(1, 0, 0, 0, 0);
    addr_r[1] = 20'h11111; addr_r[2] = 20'hABCDE;
    step(0, 3'b010, 0, 0, 0);
    step(0, 3'b110, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b100, 0, 0, 0);
      chk($sformatf("nonowner_quiet[%0d]", i), 64'({s_wn[2], s_v[2], s_addr}), 64'({2'b00, 20'h11111}));
    end
    step(0, 3'b100, 0, 1, 0);
    step(0, 3'b100, 0, 0, 0);
    chk("addr_hold_idle", 64'(s_addr), 64'(20'h11111));
    step(0, 3'b100, 0, 0, 0);
    chk("addr_switch_req", 64'({s_grant, s_addr}), 64'({3'b100, 20'hABCDE}));

    step(1, 0, 0, 0, 0);
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin pend[i] = 1'b1; addr_r[i] = 20'($urandom); end
        else if (pend[i] && $urandom_range(0, 40) == 0) pend[i] = 1'b0;
      r = $urandom_range(0, 299) == 0;
      step(r, pend, $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0, 16'($urandom));
      pend &= ~s_wn;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
